// File: rtl/ddr_pkg.sv
// Shared constants and FSM encoding for the simulated DDR responder.
package ddr_pkg;

   localparam int BURST_LEN = 8;
   localparam int WORD_W    = 64;
   localparam int IDX_W     = 19;
   localparam int BEAT_W    = $clog2(BURST_LEN);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_XFER = 2'd2,
      ST_DONE = 2'd3
   } state_e;

endpackage

// File: rtl/sim_ddr_resp_if.sv
// Command/response bundle between a DDR requester (master) and the responder (slave).
interface sim_ddr_resp_if;
   import ddr_pkg::*;

   logic                       ddr_chip_enable;
   logic [IDX_W-1:0]           ddr_index;
   logic                       ddr_write_enable;
   logic                       ddr_burst_mode;
   logic [WORD_W-1:0]          ddr_opstore_write_mask;
   logic [WORD_W-1:0]          ddr_opstore_write_data;
   logic [WORD_W-1:0]          ddr_opload_read_data;
   logic [BURST_LEN*WORD_W-1:0] ddr_pc_read_inst;
   logic                       ddr_operation_done;
   logic                       ddr_ready;

   modport master (
      output ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
             ddr_opstore_write_mask, ddr_opstore_write_data,
      input  ddr_opload_read_data, ddr_pc_read_inst, ddr_operation_done, ddr_ready
   );

   modport slave (
      input  ddr_chip_enable, ddr_index, ddr_write_enable, ddr_burst_mode,
             ddr_opstore_write_mask, ddr_opstore_write_data,
      output ddr_opload_read_data, ddr_pc_read_inst, ddr_operation_done, ddr_ready
   );

endinterface

// File: rtl/sim_ddr_mem_array.sv
// Word-wide storage with one asynchronous read port and one bit-masked write port.
module sim_ddr_mem_array #(
   parameter int ADDR_W = 19,
   parameter int DATA_W = 64
) (
   input  logic              clock,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [DATA_W-1:0] wr_data_i,
   input  logic [DATA_W-1:0] wr_mask_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [DATA_W-1:0] rd_data_o
);

   logic [DATA_W-1:0] mem_q [2**ADDR_W];

   // NOTE: storage has no reset; contents survive reset and a write commits whole in one edge.
   always_ff @(posedge clock) begin
      if (wr_en_i) begin
         mem_q[wr_addr_i] <= (mem_q[wr_addr_i] & ~wr_mask_i) | (wr_data_i & wr_mask_i);
      end
   end

   assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/sim_ddr_resp.sv
// Simulated DDR responder: single masked writes, single reads and 8-word wrapping bursts.
// Optional access latency through the WAIT state is enabled with `define SIMDDR_LAT_EN.
module sim_ddr_resp
   import ddr_pkg::*;
#(
   parameter int ADDR_W  = 19,
   parameter int LATENCY = 4
) (
   input  logic          clock,
   input  logic          reset,
   sim_ddr_resp_if.slave bus
);

`ifdef SIMDDR_LAT_EN
   localparam bit LAT_ON = (LATENCY != 0);
`else
   localparam bit LAT_ON = 1'b0;
`endif
   localparam logic [15:0]       WAIT_LAST = 16'(LATENCY - 1);
   localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_LEN - 1);

   state_e                      state_q;
   logic [ADDR_W-1:0]           idx_q;
   logic                        we_q;
   logic                        burst_q;
   logic [WORD_W-1:0]           mask_q;
   logic [WORD_W-1:0]           data_q;
   logic [BEAT_W-1:0]           beat_q;
   logic [15:0]                 wait_q;
   logic [WORD_W-1:0]           opload_q;
   logic [BURST_LEN*WORD_W-1:0] inst_q;
   logic                        done_q;
   logic                        ready_q;

   logic [ADDR_W-1:0] rd_addr;
   logic [WORD_W-1:0] rd_data;
   logic              mem_wr_en;

   // Burst beats walk forward from the captured index and wrap at the top of memory.
   assign rd_addr   = idx_q + ADDR_W'(beat_q);
   assign mem_wr_en = (state_q == ST_XFER) && we_q && !burst_q;

   sim_ddr_mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (WORD_W)
   ) u_mem (
      .clock     (clock),
      .wr_en_i   (mem_wr_en),
      .wr_addr_i (idx_q),
      .wr_data_i (data_q),
      .wr_mask_i (mask_q),
      .rd_addr_i (rd_addr),
      .rd_data_o (rd_data)
   );

   // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         idx_q    <= '0;
         we_q     <= 1'b0;
         burst_q  <= 1'b0;
         mask_q   <= '0;
         data_q   <= '0;
         beat_q   <= '0;
         wait_q   <= '0;
         opload_q <= '0;
         inst_q   <= '0;
         done_q   <= 1'b0;
         ready_q  <= 1'b1;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_DONE: begin
               state_q <= ST_IDLE;
               ready_q <= 1'b1;
               if (bus.ddr_chip_enable) begin
                  idx_q   <= bus.ddr_index[ADDR_W-1:0];
                  we_q    <= bus.ddr_write_enable;
                  burst_q <= bus.ddr_burst_mode;
                  mask_q  <= bus.ddr_opstore_write_mask;
                  data_q  <= bus.ddr_opstore_write_data;
                  beat_q  <= '0;
                  wait_q  <= '0;
                  ready_q <= 1'b0;
                  state_q <= LAT_ON ? ST_WAIT : ST_XFER;
               end
            end
            ST_WAIT: begin
               wait_q <= wait_q + 16'd1;
               if (wait_q == WAIT_LAST) state_q <= ST_XFER;
            end
            ST_XFER: begin
               if (burst_q) begin
                  inst_q[int'(beat_q)*WORD_W +: WORD_W] <= rd_data;
                  beat_q <= beat_q + 1'b1;
                  if (beat_q == BEAT_LAST) begin
                     state_q <= ST_DONE;
                     ready_q <= 1'b1;
                     done_q  <= 1'b1;
                  end
               end else begin
                  if (!we_q) opload_q <= rd_data;
                  state_q <= ST_DONE;
                  ready_q <= 1'b1;
                  done_q  <= 1'b1;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.ddr_opload_read_data = opload_q;
   assign bus.ddr_pc_read_inst     = inst_q;
   assign bus.ddr_operation_done   = done_q;
   assign bus.ddr_ready            = ready_q;

endmodule

// File: tb/tb_sim_ddr_resp.sv
// Scoreboard bench for sim_ddr_resp: random and directed commands against a word-array model.
module tb_sim_ddr_resp;
   import ddr_pkg::*;

   localparam int ADDR_W  = 19;
   localparam int LATENCY = 4;
`ifdef SIMDDR_LAT_EN
   localparam int LAT = LATENCY;
`else
   localparam int LAT = 0;
`endif
   localparam int DEPTH = 2**ADDR_W;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   sim_ddr_resp_if bus_if ();

   sim_ddr_resp #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
      .clock (clk),
      .reset (rst),
      .bus   (bus_if)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_pass  = 0;
   int n_total = 0;

   typedef struct {
      string        name;
      int           done_cyc;
      logic [63:0]  opload;
      logic [511:0] inst;
   } exp_t;

   exp_t         sb_q[$];
   logic [63:0]  model_mem [int];
   logic [63:0]  last_op   = '0;
   logic [511:0] last_inst = '0;

   task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   // Monitor: every completion pulse is matched against the oldest outstanding expectation.
   always @(negedge clk) begin
      exp_t e;
      if (!rst && bus_if.ddr_operation_done === 1'b1) begin
         if (sb_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check({e.name, "_done_cycle"}, cyc, e.done_cyc);
            check({e.name, "_ready"}, bus_if.ddr_ready, 1);
            check({e.name, "_opload"}, bus_if.ddr_opload_read_data, e.opload);
            check({e.name, "_inst"}, bus_if.ddr_pc_read_inst, e.inst);
         end
      end
   end

   // Call at #1 after a rising edge; returns #1 after the accepting edge (or after done if hold).
   task automatic issue(input string name, input int idx, input bit we, input bit burst,
                        input logic [63:0] mask, input logic [63:0] data, input bit hold);
      exp_t e;
      int   guard = 0;
      while (bus_if.ddr_ready !== 1'b1 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 100) check({name, "_ready_timeout"}, 0, 1);
      bus_if.ddr_chip_enable        = 1'b1;
      bus_if.ddr_index              = IDX_W'(idx);
      bus_if.ddr_write_enable       = we;
      bus_if.ddr_burst_mode         = burst;
      bus_if.ddr_opstore_write_mask = mask;
      bus_if.ddr_opstore_write_data = data;
      e.name = name;
      if (burst) begin
         for (int k = 0; k < BURST_LEN; k++)
            last_inst[64*k +: 64] = model_mem[(idx + k) % DEPTH];
         e.done_cyc = cyc + 9 + LAT;
      end else if (we) begin
         model_mem[idx] = (model_mem[idx] & ~mask) | (data & mask);
         e.done_cyc = cyc + 2 + LAT;
      end else begin
         last_op = model_mem[idx];
         e.done_cyc = cyc + 2 + LAT;
      end
      e.opload = last_op;
      e.inst   = last_inst;
      sb_q.push_back(e);
      @(posedge clk); #1;
      if (hold) begin
         guard = 0;
         while (bus_if.ddr_operation_done !== 1'b1 && guard < 100) begin
            @(posedge clk); #1;
            guard++;
         end
      end
      bus_if.ddr_chip_enable = 1'b0;
   endtask

   function automatic int pool_addr();
      int r = $urandom_range(0, 47);
      return (r < 32) ? r : 'h7FFF0 + (r - 32);
   endfunction

   function automatic int burst_base();
      int r = $urandom_range(0, 40);
      return (r < 25) ? r : 'h7FFF0 + (r - 25);
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int          a;
      int          guard;
      logic [63:0] m;
      bus_if.ddr_chip_enable        = 1'b0;
      bus_if.ddr_index              = '0;
      bus_if.ddr_write_enable       = 1'b0;
      bus_if.ddr_burst_mode         = 1'b0;
      bus_if.ddr_opstore_write_mask = '0;
      bus_if.ddr_opstore_write_data = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("reset_ready", bus_if.ddr_ready, 1);
      check("reset_done", bus_if.ddr_operation_done, 0);
      check("reset_opload", bus_if.ddr_opload_read_data, 0);
      check("reset_inst", bus_if.ddr_pc_read_inst, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Fill the working address pool so every later read has a known value.
      for (int i = 0; i < 48; i++) begin
         a = (i < 32) ? i : 'h7FFF0 + (i - 32);
         issue("preload", a, 1'b1, 1'b0, '1, {$urandom, $urandom}, 1'b0);
      end

      issue("wr_full", 'h10, 1'b1, 1'b0, '1, 64'hFFFF_0000_1234_5678, 1'b0);
      issue("rd_full", 'h10, 1'b0, 1'b0, '0, '0, 1'b0);
      issue("wr_ones", 'h10, 1'b1, 1'b0, '1, '1, 1'b0);
      issue("wr_lowmask", 'h10, 1'b1, 1'b0, 64'h0000_0000_FFFF_FFFF, '0, 1'b0);
      issue("rd_lowmask", 'h10, 1'b0, 1'b0, '0, '0, 1'b0);
      issue("wr_mask0", 'h10, 1'b1, 1'b0, '0, '1, 1'b0);
      issue("rd_mask0", 'h10, 1'b0, 1'b0, '0, '0, 1'b0);

      issue("pre_7fffe", 'h7FFFE, 1'b1, 1'b0, '1, 64'd1, 1'b0);
      issue("pre_7ffff", 'h7FFFF, 1'b1, 1'b0, '1, 64'd2, 1'b0);
      for (int i = 0; i < 6; i++) issue("pre_low", i, 1'b1, 1'b0, '1, 64'(i + 3), 1'b0);
      issue("burst_wrap", 'h7FFFE, 1'b0, 1'b1, '0, '0, 1'b0);
      issue("burst_we_set", 'h7FFFE, 1'b1, 1'b1, '1, '0, 1'b0);

      issue("rd_hold", 'h3, 1'b0, 1'b0, '0, '0, 1'b1);
      issue("burst_hold", 'h8, 1'b0, 1'b1, '0, '0, 1'b1);
      issue("b2b_a", 'h4, 1'b0, 1'b0, '0, '0, 1'b0);
      issue("b2b_b", 'h5, 1'b0, 1'b0, '0, '0, 1'b0);

      for (int i = 0; i < 60; i++) begin
         case ($urandom_range(0, 2))
            0: begin
               m = ($urandom_range(0, 4) == 0) ? 64'd0 : {$urandom, $urandom};
               issue("rnd_wr", pool_addr(), 1'b1, 1'b0, m, {$urandom, $urandom}, 1'b0);
            end
            1: issue("rnd_rd", pool_addr(), 1'b0, 1'b0, '0, '0, 1'(i % 7 == 0));
            default: issue("rnd_burst", burst_base(), 1'($urandom_range(0, 1)), 1'b1, '0, '0, 1'b0);
         endcase
      end

      // Reset in the middle of a burst abandons it; memory keeps its contents.
      issue("burst_rst", 'h7FFF8, 1'b0, 1'b1, '0, '0, 1'b0);
      repeat (3) @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      check("midrst_ready", bus_if.ddr_ready, 1);
      check("midrst_done", bus_if.ddr_operation_done, 0);
      check("midrst_opload", bus_if.ddr_opload_read_data, 0);
      check("midrst_inst", bus_if.ddr_pc_read_inst, 0);
      sb_q.delete();
      last_op   = '0;
      last_inst = '0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      issue("post_rst_rd", 'h7FFF9, 1'b0, 1'b0, '0, '0, 1'b0);
      issue("post_rst_burst", 'h7FFF8, 1'b0, 1'b1, '0, '0, 1'b0);

      guard = 0;
      while (sb_q.size() != 0 && guard < 200) begin
         @(posedge clk); #1;
         guard++;
      end
      check("drain_outstanding", sb_q.size(), 0);
      repeat (3) @(posedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
